// File: rtl/pipe_execute_if.sv
// pipe_execute_if: E-register inputs, M/W status and execute-stage results for the Y86-64 execute unit.
interface pipe_execute_if #(parameter int WIDTH = 64);
  logic             E_valid;
  logic             E_flush;
  logic [3:0]       E_icode;
  logic [3:0]       E_ifun;
  logic [WIDTH-1:0] E_valA;
  logic [WIDTH-1:0] E_valB;
  logic [WIDTH-1:0] E_valC;
  logic [3:0]       E_dstE;
  logic [2:0]       m_stat;
  logic [2:0]       W_stat;
  logic [WIDTH-1:0] e_valE;
  logic [3:0]       e_dstE;
  logic             e_cnd;
  logic             e_busy;
  logic [2:0]       cc;
  modport master (
    output E_valid, E_flush, E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, m_stat, W_stat,
    input  e_valE, e_dstE, e_cnd, e_busy, cc
  );
  modport slave (
    input  E_valid, E_flush, E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, m_stat, W_stat,
    output e_valE, e_dstE, e_cnd, e_busy, cc
  );
endinterface

// File: rtl/pipe_execute_unit.sv
// pipe_execute_unit: Y86-64 execute stage with CC register, cmov/jXX condition and an iterative signed mulq.
module pipe_execute_unit #(
  parameter int WIDTH      = 64,
  parameter int MUL_EN     = 1,
  parameter int STACK_STEP = 8
) (
  input logic         clk,
  input logic         rst_n,
  pipe_execute_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t             state;
  logic [2*WIDTH-1:0] prod, mcand;
  logic [WIDTH-1:0]   mplier, alu_a, alu_b, sum, diff, val_e;
  logic [CW-1:0]      count;
  logic [3:0]         ic, fn;
  logic [2:0]         cc_q;
  logic               mul_fn, fn_ok, mul_go, cc_en, stat_ok, of, of_mul, cnd, zf, sf, ovf;
  assign ic = bus.E_icode;
  assign {zf, sf, ovf} = cc_q;
  always_comb begin
    alu_a   = (ic inside {4'h2, 4'h6}) ? bus.E_valA :
              (ic inside {4'h3, 4'h4, 4'h5}) ? bus.E_valC :
              (ic inside {4'h8, 4'hA}) ? -WIDTH'(STACK_STEP) :
              (ic inside {4'h9, 4'hB}) ? WIDTH'(STACK_STEP) : '0;
    alu_b   = (ic inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) ? bus.E_valB : '0;
    fn      = (ic == 4'h6) ? bus.E_ifun : 4'h0;
    mul_fn  = (fn == 4'h4) && (MUL_EN != 0);
    fn_ok   = (fn < 4'h4) || mul_fn;
    sum     = alu_b + alu_a;
    diff    = alu_b - alu_a;
    val_e   = (fn == 4'h0) ? sum :
              (fn == 4'h1) ? diff :
              (fn == 4'h2) ? (alu_b & alu_a) :
              (fn == 4'h3) ? (alu_b ^ alu_a) :
              (mul_fn && state == DONE) ? prod[WIDTH-1:0] : '0;
    // mulq overflows when the upper half is not the sign extension of the low half
    of_mul  = prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}};
    of      = (fn == 4'h0) ? ((alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (sum[WIDTH-1] != alu_b[WIDTH-1])) :
              (fn == 4'h1) ? ((alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (diff[WIDTH-1] != alu_b[WIDTH-1])) :
              mul_fn ? of_mul : 1'b0;
    mul_go  = bus.E_valid && (ic == 4'h6) && mul_fn && !bus.E_flush;
    stat_ok = (bus.m_stat <= 3'd1) && (bus.W_stat <= 3'd1);
    cc_en   = bus.E_valid && (ic == 4'h6) && fn_ok && !bus.E_flush && stat_ok &&
              (mul_fn ? (state == DONE) : (state == IDLE));
    cnd     = !(ic inside {4'h2, 4'h7}) ? 1'b0 :
              (bus.E_ifun == 4'h0) ? 1'b1 :
              (bus.E_ifun == 4'h1) ? ((sf ^ ovf) | zf) :
              (bus.E_ifun == 4'h2) ? (sf ^ ovf) :
              (bus.E_ifun == 4'h3) ? zf :
              (bus.E_ifun == 4'h4) ? !zf :
              (bus.E_ifun == 4'h5) ? !(sf ^ ovf) :
              (bus.E_ifun == 4'h6) ? (!(sf ^ ovf) && !zf) : 1'b0;
  end
  assign bus.e_valE = val_e;
  assign bus.e_cnd  = cnd;
  assign bus.e_dstE = (ic == 4'h2 && !cnd) ? 4'hF : bus.E_dstE;
  assign bus.e_busy = (state == IDLE && mul_go) || (state == MUL && !bus.E_flush);
  assign bus.cc     = cc_q;
  // Shift-add over the multiplier bits; the MSB carries negative weight, giving the full signed product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cc_q   <= 3'b100;
      prod   <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else begin
      if (cc_en) cc_q <= {val_e == '0, val_e[WIDTH-1], of};
      case (state)
        IDLE: if (mul_go) begin
          mcand  <= {{WIDTH{bus.E_valB[WIDTH-1]}}, bus.E_valB};
          mplier <= bus.E_valA;
          prod   <= '0;
          count  <= CW'(WIDTH);
          state  <= MUL;
        end
        MUL: if (bus.E_flush) state <= IDLE;
        else begin
          if (mplier[0]) prod <= (count == CW'(1)) ? prod - mcand : prod + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count - CW'(1);
          if (count == CW'(1)) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pipe_execute_unit.sv
// tb_pipe_execute_unit: directed and randomized checks of the execute stage against a behavioural model.
module tb_pipe_execute_unit;
  localparam int W = 64;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  pipe_execute_if #(.WIDTH(W)) bus();
  pipe_execute_unit #(.WIDTH(W), .MUL_EN(1), .STACK_STEP(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int vectors = 0, miscompares = 0;
  logic [2:0] model_cc;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic ref_cnd(input logic [3:0] f, input logic [2:0] c);
    logic zf, sf, of;
    {zf, sf, of} = c;
    case (f)
      4'h0: return 1'b1;
      4'h1: return (sf != of) || zf;
      4'h2: return sf != of;
      4'h3: return zf;
      4'h4: return !zf;
      4'h5: return sf == of;
      4'h6: return (sf == of) && !zf;
      default: return 1'b0;
    endcase
  endfunction
  function automatic logic [63:0] rv();
    case ($urandom_range(0, 7))
      0: return 64'h0;
      1: return 64'h7FFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'hFFFF_FFFF_FFFF_FFFF;
      4: return 64'h1;
      default: return {$urandom, $urandom};
    endcase
  endfunction
  task automatic drive(input logic v, f, input logic [3:0] ic, fn, input logic [63:0] a, b, c,
                       input logic [3:0] d, input logic [2:0] ms, ws);
    bus.E_valid = v; bus.E_flush = f; bus.E_icode = ic; bus.E_ifun = fn;
    bus.E_valA = a; bus.E_valB = b; bus.E_valC = c; bus.E_dstE = d;
    bus.m_stat = ms; bus.W_stat = ws;
  endtask
  task automatic run_op(input logic v, f, input logic [3:0] ic, fn, input logic [63:0] a, b, c,
                        input logic [3:0] d, input logic [2:0] ms, ws);
    logic [63:0] ev;
    logic signed [64:0] wide;
    logic of, cn;
    logic [3:0] ed;
    @(posedge clk); #1;
    drive(v, f, ic, fn, a, b, c, d, ms, ws);
    ev = 0; wide = 0;
    case (ic)
      4'h2: ev = a;
      4'h3: ev = c;
      4'h4, 4'h5: ev = b + c;
      4'h6: case (fn)
        4'h0: begin ev = b + a; wide = $signed({b[63], b}) + $signed({a[63], a}); end
        4'h1: begin ev = b - a; wide = $signed({b[63], b}) - $signed({a[63], a}); end
        4'h2: ev = b & a;
        4'h3: ev = b ^ a;
        default: ev = 0;
      endcase
      4'h8, 4'hA: ev = b - 64'd8;
      4'h9, 4'hB: ev = b + 64'd8;
      default: ev = 0;
    endcase
    of = (ic == 4'h6 && fn <= 4'h1) && (wide != $signed({ev[63], ev}));
    cn = (ic == 4'h2 || ic == 4'h7) ? ref_cnd(fn, model_cc) : 1'b0;
    ed = (ic == 4'h2 && !cn) ? 4'hF : d;
    @(negedge clk);
    check("valE", bus.e_valE, ev);
    check("dstE", bus.e_dstE, ed);
    check("cnd", bus.e_cnd, cn);
    check("busy", bus.e_busy, 0);
    check("cc", bus.cc, model_cc);
    if (v && ic == 4'h6 && fn <= 4'h3 && !f && ms <= 3'd1 && ws <= 3'd1) model_cc = {ev == 0, ev[63], of};
  endtask
  task automatic bubble();
    @(posedge clk); #1;
    bus.E_valid = 0; bus.E_flush = 0; bus.E_icode = 4'h1; bus.m_stat = 0; bus.W_stat = 0;
    @(negedge clk);
    check("bubble_cc", bus.cc, model_cc);
    check("bubble_busy", bus.e_busy, 0);
  endtask
  task automatic do_mul(input logic [63:0] a, b, input int flush_at, input logic [2:0] ms);
    logic signed [127:0] p;
    logic [63:0] lo;
    int n;
    p = 128'($signed(b)) * 128'($signed(a));
    lo = p[63:0];
    @(posedge clk); #1;
    drive(1, 0, 4'h6, 4'h4, a, b, 0, 4'h3, ms, 0);
    @(negedge clk);
    n = 0;
    while (bus.e_busy && n < 200) begin
      n++;
      @(posedge clk); #1;
      if (n == flush_at) bus.E_flush = 1;
      @(negedge clk);
    end
    if (flush_at > 0) check("mul_busy_flush", n, flush_at);
    else begin
      check("mul_busy_cycles", n, W + 1);
      check("mul_valE", bus.e_valE, lo);
      if (ms <= 3'd1) model_cc = {lo == 0, lo[63], p != {{64{lo[63]}}, lo}};
    end
    @(posedge clk); #1;
    bus.E_valid = 0; bus.E_flush = 0; bus.m_stat = 0;
    @(negedge clk);
    check("mul_cc", bus.cc, model_cc);
    check("mul_idle", bus.e_busy, 0);
  endtask
  initial begin
    int nmul;
    logic [3:0] ic, fn;
    logic v, f;
    drive(0, 0, 4'h1, 0, 0, 0, 0, 4'hF, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cc", bus.cc, 3'b100);
    check("rst_busy", bus.e_busy, 0);
    model_cc = 3'b100;
    @(posedge clk); #1 rst_n = 1;
    run_op(1, 0, 4'h2, 4'h0, 64'd5, 0, 0, 4'h3, 0, 0);
    check("rrmovq_cnd", bus.e_cnd, 1);
    run_op(1, 0, 4'h2, 4'h4, 64'd5, 0, 0, 4'h3, 0, 0);
    check("cmovne_cnd", bus.e_cnd, 0);
    check("cmovne_dst", bus.e_dstE, 4'hF);
    run_op(1, 0, 4'h6, 4'h1, 64'd1, 64'd0, 0, 4'h3, 0, 0);
    check("subq_valE", bus.e_valE, 64'hFFFF_FFFF_FFFF_FFFF);
    bubble();
    check("subq_cc", bus.cc, 3'b010);
    run_op(1, 0, 4'h7, 4'h2, 0, 0, 0, 4'hF, 0, 0);
    check("jl_cnd", bus.e_cnd, 1);
    run_op(1, 0, 4'h7, 4'h6, 0, 0, 0, 4'hF, 0, 0);
    check("jg_cnd", bus.e_cnd, 0);
    run_op(1, 0, 4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 4'h3, 3'd3, 0);
    bubble();
    check("addq_sadr_cc", bus.cc, 3'b010);
    run_op(1, 0, 4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 4'h3, 0, 0);
    check("addq_valE", bus.e_valE, 64'h8000_0000_0000_0000);
    bubble();
    check("addq_cc", bus.cc, 3'b011);
    do_mul(64'd7, -64'sd3, 0, 0);
    check("mul_neg_cc", bus.cc, 3'b010);
    do_mul(64'h1_0000_0000, 64'h1_0000_0000, 0, 0);
    check("mul_ovf_cc", bus.cc, 3'b101);
    do_mul(64'd5, 64'd9, 10, 0);
    check("mul_flush_cc", bus.cc, 3'b101);
    @(posedge clk); #1;
    drive(1, 0, 4'h6, 4'h4, 64'd11, 64'd13, 0, 4'h3, 0, 0);
    repeat (20) @(posedge clk);
    #2 rst_n = 0; bus.E_valid = 0;
    #1;
    check("rst_mid_busy", bus.e_busy, 0);
    check("rst_mid_cc", bus.cc, 3'b100);
    model_cc = 3'b100;
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    check("rst_after_busy", bus.e_busy, 0);
    run_op(1, 0, 4'h6, 4'h1, 64'd3, 64'd9, 0, 4'h3, 0, 0);
    run_op(1, 0, 4'hA, 4'h0, 0, 64'h100, 0, 4'h4, 0, 0);
    check("pushq_valE", bus.e_valE, 64'hF8);
    run_op(1, 0, 4'hB, 4'h0, 0, 64'h100, 0, 4'h4, 0, 0);
    check("popq_valE", bus.e_valE, 64'h108);
    run_op(1, 0, 4'h3, 4'h0, 0, 0, 64'd5, 4'h2, 0, 0);
    check("irmovq_valE", bus.e_valE, 64'd5);
    bubble();
    check("stack_cc", bus.cc, 3'b000);
    nmul = 0;
    for (int i = 0; i < 200; i++) begin
      ic = 4'($urandom_range(0, 13));
      fn = 4'($urandom_range(0, 7));
      v  = $urandom_range(0, 7) != 0;
      f  = $urandom_range(0, 7) == 0;
      if (ic == 4'h6 && fn == 4'h4 && v && !f) begin
        if (nmul < 8) begin
          nmul++;
          do_mul(rv(), rv(), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 64)) : 0,
                 ($urandom_range(0, 3) == 0) ? 3'($urandom_range(2, 4)) : 3'($urandom_range(0, 1)));
        end else v = 0;
      end
      if (!(ic == 4'h6 && fn == 4'h4 && v && !f))
        run_op(v, f, ic, fn, rv(), rv(), rv(), 4'($urandom_range(0, 15)),
               ($urandom_range(0, 3) == 0) ? 3'($urandom_range(2, 4)) : 3'($urandom_range(0, 1)),
               ($urandom_range(0, 5) == 0) ? 3'($urandom_range(2, 4)) : 3'($urandom_range(0, 1)));
    end
    bubble();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
